// File: rtl/bit_serializer_pkg.sv
// Shared types and constants for bit_serializer.
// BIT_SERIALIZER_PARITY_EN adds a trailing even-parity bit to every word.
package bit_serializer_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam int unsigned DEF_WIDTH      = 8;
  localparam logic        DEF_IDLE_LEVEL = 1'b0;

`ifdef BIT_SERIALIZER_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  // Serial bit slots per word: data bits plus an optional parity bit.
  function automatic int unsigned nbits_f(input int unsigned width, input bit parity_en);
    return parity_en ? width + 1 : width;
  endfunction

endpackage

// File: rtl/ser_shift_reg.sv
// Loadable shift register; next_bit is the bit that follows the current head.
// 1-cycle load/shift; no backpressure, ld takes priority over shift_en.
module ser_shift_reg #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_dat,
  input  logic             shift_en,
  output logic             next_bit
);

  logic [WIDTH-1:0] sreg_q;
  logic [WIDTH-1:0] sreg_d;

  always_comb begin
    sreg_d = sreg_q;
    if (ld) begin
      sreg_d = ld_dat;
    end else if (shift_en) begin
      if (MSB_FIRST) sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
      else           sreg_d = {1'b0, sreg_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sreg_q <= '0;
    else        sreg_q <= sreg_d;
  end

  // The head bit is already on x; the top registers the one behind it.
  assign next_bit = MSB_FIRST ? sreg_q[WIDTH-2] : sreg_q[1];

endmodule

// File: rtl/bit_serializer.sv
// Serializes a parallel word onto x, one bit per clock; first bit 1 cycle after load accept.
// ready drops while shifting and rises in the last bit cycle for gapless words; BIT_SERIALIZER_PARITY_EN adds parity.
module bit_serializer
  import bit_serializer_pkg::*;
#(
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter bit          MSB_FIRST  = 1'b1,
  parameter logic        IDLE_LEVEL = DEF_IDLE_LEVEL
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic             ready,
  output logic             x,
  output logic             valid,
  output logic             done
);

  localparam int unsigned NBITS = nbits_f(WIDTH, PARITY_EN);
  localparam int unsigned CW    = $clog2(WIDTH + 2);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          x_q, x_d;
  logic          valid_q, valid_d;
  logic          ready_q, ready_d;
  logic          done_q, done_d;
  logic          arm_q, arm_d;
`ifdef BIT_SERIALIZER_PARITY_EN
  logic          par_q, par_d;
`endif

  logic sr_ld;
  logic sr_shift;
  logic next_bit;
  logic accept;
  logic last_bit;
  logic first_bit;

  ser_shift_reg #(
    .WIDTH    (WIDTH),
    .MSB_FIRST(MSB_FIRST)
  ) u_sreg (
    .clk     (clk),
    .rst_n   (rst),
    .ld      (sr_ld),
    .ld_dat  (din),
    .shift_en(sr_shift),
    .next_bit(next_bit)
  );

  // arm_q keeps the edge that releases reset from accepting a load.
  assign accept    = load && ready_q && arm_q;
  assign last_bit  = (state_q == ST_SHIFT) && (cnt_q == CW'(NBITS - 1));
  assign first_bit = MSB_FIRST ? din[WIDTH-1] : din[0];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    x_d      = x_q;
    valid_d  = valid_q;
    ready_d  = ready_q;
    done_d   = 1'b0;
    arm_d    = 1'b1;
    sr_ld    = 1'b0;
    sr_shift = 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
    par_d    = par_q;
`endif

    if (state_q == ST_SHIFT && !last_bit) begin
      cnt_d    = cnt_q + CW'(1);
      sr_shift = 1'b1;
      valid_d  = 1'b1;
      ready_d  = ((cnt_q + CW'(1)) == CW'(NBITS - 1));
`ifdef BIT_SERIALIZER_PARITY_EN
      x_d      = (cnt_q == CW'(WIDTH - 1)) ? par_q : next_bit;
`else
      x_d      = next_bit;
`endif
    end else begin
      done_d = last_bit;
      if (accept) begin
        state_d = ST_SHIFT;
        cnt_d   = '0;
        x_d     = first_bit;
        valid_d = 1'b1;
        ready_d = 1'b0;
        sr_ld   = 1'b1;
`ifdef BIT_SERIALIZER_PARITY_EN
        par_d   = ^din;
`endif
      end else begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        x_d     = IDLE_LEVEL;
        valid_d = 1'b0;
        ready_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      x_q     <= IDLE_LEVEL;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      arm_q   <= 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      arm_q   <= arm_d;
`ifdef BIT_SERIALIZER_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign x     = x_q;
  assign valid = valid_q;
  assign ready = ready_q;
  assign done  = done_q;

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: MSB-first/idle-0 and LSB-first/idle-1 instances.
module tb_bit_serializer;

`ifdef BIT_SERIALIZER_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       load, load2;
  logic [7:0] din, din2;
  logic       ready, x, valid, done;
  logic       ready2, x2, valid2, done2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut (
    .clk(clk), .rst(rst), .load(load), .din(din),
    .ready(ready), .x(x), .valid(valid), .done(done)
  );

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) dut_lsb (
    .clk(clk), .rst(rst), .load(load2), .din(din2),
    .ready(ready2), .x(x2), .valid(valid2), .done(done2)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic logic exp_bit(input logic [7:0] w, input int i, input bit msb);
    if (i >= 8) return ^w;
    return msb ? w[7-i] : w[i];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic kick(input logic [7:0] w);
    load = 1'b1;
    din  = w;
    tick();
    load = 1'b0;
  endtask

  // Called in the first bit cycle of word w; walks every bit slot.
  task automatic word(input string tag, input logic [7:0] w, input bit b2b_in,
                      input bit hold_busy, input bit chain, input logic [7:0] nw);
    for (int i = 0; i < NB; i++) begin
      chk($sformatf("%s_x%0d", tag, i), x, exp_bit(w, i, 1'b1));
      chk($sformatf("%s_valid%0d", tag, i), valid, 1'b1);
      chk($sformatf("%s_ready%0d", tag, i), ready, (i == NB - 1));
      chk($sformatf("%s_done%0d", tag, i), done, (i == 0) && b2b_in);
      load = 1'b0;
      if (hold_busy && i < NB - 1) begin
        load = 1'b1;
        din  = 8'h0F;
      end
      if (chain && i == NB - 1) begin
        load = 1'b1;
        din  = nw;
      end
      tick();
    end
    load = 1'b0;
    if (!chain) begin
      chk({tag, "_done_end"}, done, 1'b1);
      chk({tag, "_valid_end"}, valid, 1'b0);
      chk({tag, "_x_end"}, x, 1'b0);
      chk({tag, "_ready_end"}, ready, 1'b1);
      tick();
      chk({tag, "_done_clr"}, done, 1'b0);
      chk({tag, "_x_idle"}, x, 1'b0);
    end
  endtask

  initial begin
    rst   = 1'b0;
    load  = 1'b0;
    din   = 8'h00;
    load2 = 1'b0;
    din2  = 8'h00;
    #12;
    chk("rst_x", x, 1'b0);
    chk("rst_ready", ready, 1'b1);
    chk("rst_valid", valid, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_x2", x2, 1'b1);

    // Release reset mid-cycle with load high: the release edge must not accept.
    tick();
    load = 1'b1;
    din  = 8'hB4;
    #3 rst = 1'b1;
    tick();
    chk("rel_no_accept_valid", valid, 1'b0);
    chk("rel_no_accept_ready", ready, 1'b1);
    tick();
    word("b4", 8'hB4, 1'b0, 1'b0, 1'b0, 8'h00);

    // Back-to-back FF then 00 with no gap.
    kick(8'hFF);
    word("ff", 8'hFF, 1'b0, 1'b0, 1'b1, 8'h00);
    word("z", 8'h00, 1'b1, 1'b0, 1'b0, 8'h00);

    // Busy loads with din=0F are ignored until the last bit cycle.
    kick(8'hB4);
    word("busy", 8'hB4, 1'b0, 1'b1, 1'b1, 8'h0F);
    word("acc0f", 8'h0F, 1'b1, 1'b0, 1'b0, 8'h00);

    // Reset in the third bit cycle of a word.
    kick(8'hB4);
    tick();
    tick();
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_x", x, 1'b0);
    chk("mid_rst_valid", valid, 1'b0);
    chk("mid_rst_ready", ready, 1'b1);
    chk("mid_rst_done", done, 1'b0);
    tick();
    #2 rst = 1'b1;
    tick();
    chk("post_rst_done", done, 1'b0);
    chk("post_rst_valid", valid, 1'b0);
    kick(8'h81);
    word("r81", 8'h81, 1'b0, 1'b0, 1'b0, 8'h00);

    // LSB-first instance idling high.
    chk("lsb_idle_before", x2, 1'b1);
    chk("lsb_ready_before", ready2, 1'b1);
    load2 = 1'b1;
    din2  = 8'h01;
    tick();
    load2 = 1'b0;
    din2  = 8'hFE;
    for (int i = 0; i < NB; i++) begin
      chk($sformatf("lsb_x%0d", i), x2, exp_bit(8'h01, i, 1'b0));
      chk($sformatf("lsb_valid%0d", i), valid2, 1'b1);
      tick();
    end
    chk("lsb_done", done2, 1'b1);
    chk("lsb_valid_end", valid2, 1'b0);
    chk("lsb_idle_after", x2, 1'b1);
    tick();
    chk("lsb_done_clr", done2, 1'b0);
    chk("lsb_idle_after2", x2, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
